// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch/button input conditioning path.
package debounce_pkg;

  localparam int CLK_HZ      = 12_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms worth of board clock cycles
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  localparam int SW_LSB     = 0;
  localparam int SW_MSB     = 7;
  localparam int SWITCH_BIT = 8;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, bounce counter, stable level and edge strobes.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The next-cycle strobes are exported so the top can update its latches on the same edge
  assign accept    = (s2 != stable) && (cnt == LAST);
  assign rise_next = accept & s2;
  assign fall_next = accept & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= rise_next;
      fall <= fall_next;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces the slide switches and push button; adds a change flag and a button toggle latch.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH           = 9,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TOGGLE_BIT      = SWITCH_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             toggle
);

  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw[i]),
      .stable   (stable[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .rise_next(rise_next[i]),
      .fall_next(fall_next[i])
    );
  end

  // Registered from the next-cycle strobes so both outputs line up with rise/fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
      toggle  <= 1'b0;
    end else begin
      changed <= |(rise_next | fall_next);
      toggle  <= toggle ^ rise_next[TOGGLE_BIT];
    end
  end

endmodule
